// File: rtl/quiescence_slot_gate.sv
// Per-slot quiescence client: gates the slot's memory request path, drains it, and answers checks.
// Optional define QUIESCE_STATS_EN adds a drain-cycle counter reported in response bits [63:32].

package quiescence_slot_gate_pkg;
  typedef struct packed {
    logic        valid;
    logic        isRequest;
    logic [63:0] data;
  } QuiescenceReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } QuiescenceResp;
endpackage

module quiescence_slot_gate
  import quiescence_slot_gate_pkg::*;
#(
  parameter int unsigned REQ_WIDTH       = 512,
  parameter int unsigned CNT_WIDTH       = 8,
  parameter int unsigned MAX_OUTSTANDING = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  QuiescenceReq         quiescence_req,
  output QuiescenceResp        quiescence_resp,
  input  logic                 app_req_valid,
  input  logic [REQ_WIDTH-1:0] app_req_data,
  output logic                 app_req_ready,
  output logic                 mem_req_valid,
  output logic [REQ_WIDTH-1:0] mem_req_data,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_fire,
  output logic                 quiesced,
  output logic                 cnt_err
);

  typedef enum logic [1:0] {StRunning, StDraining, StQuiesced} state_e;

  localparam logic [CNT_WIDTH-1:0] MaxCnt = CNT_WIDTH'(MAX_OUTSTANDING);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] outstanding_q, outstanding_d;
  logic                 cnt_err_q, cnt_err_d;
  logic                 quiesced_q, quiesced_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [63:0]          resp_data_q, resp_data_d;

  logic can_issue, fire, quiesce_cmd, resume_cmd, check_cmd;
  logic unused_req_data;

  assign unused_req_data = ^quiescence_req.data[63:1];

  assign quiesce_cmd = quiescence_req.valid & quiescence_req.isRequest & quiescence_req.data[0];
  assign resume_cmd  = quiescence_req.valid & quiescence_req.isRequest & ~quiescence_req.data[0];
  assign check_cmd   = quiescence_req.valid & ~quiescence_req.isRequest;

  assign can_issue     = (state_q == StRunning) && (outstanding_q != MaxCnt);
  assign mem_req_valid = app_req_valid & can_issue;
  assign app_req_ready = mem_req_ready & can_issue;
  assign mem_req_data  = app_req_data;
  assign fire          = mem_req_valid & mem_req_ready;

`ifdef QUIESCE_STATS_EN
  logic [31:0] drain_cycles_q, drain_cycles_d;
`endif

  always_comb begin
    outstanding_d = outstanding_q;
    cnt_err_d     = cnt_err_q;
    // A completion with nothing outstanding is an environment error; never wrap below zero.
    if (fire && !mem_resp_fire) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!fire && mem_resp_fire) begin
      if (outstanding_q == '0) begin
        cnt_err_d = 1'b1;
      end else begin
        outstanding_d = outstanding_q - 1'b1;
      end
    end

    state_d = state_q;
    unique case (state_q)
      StRunning:  if (quiesce_cmd) state_d = StDraining;
      StDraining: begin
        if (resume_cmd) begin
          state_d = StRunning;
        end else if (outstanding_q == '0) begin
          state_d = StQuiesced;
        end
      end
      StQuiesced: if (resume_cmd) state_d = StRunning;
      default:    state_d = StRunning;
    endcase

    quiesced_d   = (state_d == StQuiesced);
    resp_valid_d = check_cmd;
`ifdef QUIESCE_STATS_EN
    drain_cycles_d = drain_cycles_q;
    if (state_q != StDraining && state_d == StDraining) begin
      drain_cycles_d = '0;
    end else if (state_q == StDraining && drain_cycles_q != 32'hFFFF_FFFF) begin
      drain_cycles_d = drain_cycles_q + 32'd1;
    end
    resp_data_d = {drain_cycles_q, 31'b0, state_q == StQuiesced};
`else
    resp_data_d = {63'b0, state_q == StQuiesced};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRunning;
      outstanding_q <= '0;
      cnt_err_q     <= 1'b0;
      quiesced_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      cnt_err_q     <= cnt_err_d;
      quiesced_q    <= quiesced_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
    end
  end

`ifdef QUIESCE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cycles_q <= '0;
    end else begin
      drain_cycles_q <= drain_cycles_d;
    end
  end
`endif

  assign quiescence_resp.valid = resp_valid_q;
  assign quiescence_resp.data  = resp_data_q;
  assign quiesced              = quiesced_q;
  assign cnt_err               = cnt_err_q;

endmodule
